// File: rtl/chimera_pkg.sv
// Shared types and defaults for the Chimera cluster power-sequencing logic.
package chimera_pkg;

   localparam int unsigned ExtClusters         = 5;
   localparam int unsigned CluRstHoldCycles    = 8;
   localparam int unsigned CluIsoTimeoutCycles = 1024;

   typedef enum logic [2:0] {
      CLU_OFF    = 3'd0,
      CLU_PU_RST = 3'd1,
      CLU_DEISO  = 3'd2,
      CLU_ACTIVE = 3'd3,
      CLU_ISO    = 3'd4,
      CLU_PD_RST = 3'd5
   } clu_pwr_state_e;

endpackage

// File: rtl/chimera_clu_pwr_fsm.sv
// Single-cluster power sequencer: state, hold/timeout counter and sticky error flag.
// Isolation-acknowledge timeout is built only with CHIMERA_CLU_PWR_TIMEOUT_EN defined.
module chimera_clu_pwr_fsm
   import chimera_pkg::*;
#(
   parameter int unsigned RstHoldCycles = CluRstHoldCycles,
   parameter int unsigned TimeoutCycles = CluIsoTimeoutCycles
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic target_en_i,
   input  logic isolated_i,
   input  logic err_clr_i,
   output logic isolate_o,
   output logic clk_en_o,
   output logic rst_no,
   output logic active_o,
   output logic busy_o,
   output logic err_o
);

   localparam int unsigned MaxCnt = (RstHoldCycles > TimeoutCycles) ? RstHoldCycles : TimeoutCycles;
   localparam int unsigned CntW   = $clog2(MaxCnt + 1);
   localparam logic [CntW-1:0] HoldLast = CntW'(RstHoldCycles - 1);

   clu_pwr_state_e  state_d, state_q;
   logic [CntW-1:0] cnt_d, cnt_q;
   logic            isolate_d, isolate_q;
   logic            clk_en_d, clk_en_q;
   logic            rst_n_d, rst_n_q;
   logic            active_d, active_q;
   logic            busy_d, busy_q;

`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
   logic err_set, err_d, err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = err_clr_i;
`endif

   always_comb begin
      state_d = state_q;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
      err_set = 1'b0;
`endif
      case (state_q)
         CLU_OFF:    if (target_en_i)        state_d = CLU_PU_RST;
         CLU_PU_RST: if (cnt_q == HoldLast)  state_d = CLU_DEISO;
         CLU_DEISO:  if (!isolated_i)        state_d = CLU_ACTIVE;
         CLU_ACTIVE: if (!target_en_i)       state_d = CLU_ISO;
         CLU_ISO: begin
            if (isolated_i) state_d = CLU_PD_RST;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
            // Abort the power-down rather than gate a cluster with traffic in flight.
            else if (cnt_q == TimeoutLast) begin
               state_d = CLU_DEISO;
               err_set = 1'b1;
            end
`endif
         end
         CLU_PD_RST: if (cnt_q == HoldLast)  state_d = CLU_OFF;
         default:                            state_d = CLU_OFF;
      endcase

      if (state_d != state_q)  cnt_d = '0;
      else if (cnt_q != '1)    cnt_d = cnt_q + CntW'(1);
      else                     cnt_d = cnt_q;

      // Outputs are decoded from the next state so they switch together with state_q.
      isolate_d = 1'b1;
      clk_en_d  = 1'b1;
      rst_n_d   = 1'b1;
      case (state_d)
         CLU_OFF: begin
            clk_en_d = 1'b0;
            rst_n_d  = 1'b0;
         end
         CLU_PU_RST, CLU_PD_RST: rst_n_d   = 1'b0;
         CLU_DEISO, CLU_ACTIVE:  isolate_d = 1'b0;
         default: ;
      endcase
      active_d = (state_d == CLU_ACTIVE);
      busy_d   = (state_d != CLU_ACTIVE) && (state_d != CLU_OFF);

`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
      err_d = (err_q & ~err_clr_i) | err_set;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= CLU_OFF;
         cnt_q     <= '0;
         isolate_q <= 1'b1;
         clk_en_q  <= 1'b0;
         rst_n_q   <= 1'b0;
         active_q  <= 1'b0;
         busy_q    <= 1'b0;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
         err_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         isolate_q <= isolate_d;
         clk_en_q  <= clk_en_d;
         rst_n_q   <= rst_n_d;
         active_q  <= active_d;
         busy_q    <= busy_d;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
         err_q     <= err_d;
`endif
      end
   end

   assign isolate_o = isolate_q;
   assign clk_en_o  = clk_en_q;
   assign rst_no    = rst_n_q;
   assign active_o  = active_q;
   assign busy_o    = busy_q;
`ifdef CHIMERA_CLU_PWR_TIMEOUT_EN
   assign err_o     = err_q;
`else
   assign err_o     = 1'b0;
`endif

endmodule

// File: rtl/chimera_clu_pwr_ctrl.sv
// Per-cluster power sequencing (isolate -> gate/reset) for the external cluster domain.
// Optional isolation timeout: define CHIMERA_CLU_PWR_TIMEOUT_EN.
module chimera_clu_pwr_ctrl
   import chimera_pkg::*;
#(
   parameter int unsigned NumClusters   = ExtClusters,
   parameter int unsigned RstHoldCycles = CluRstHoldCycles,
   parameter int unsigned TimeoutCycles = CluIsoTimeoutCycles
) (
   input  logic                   soc_clk_i,
   input  logic                   rst_ni,
   input  logic [NumClusters-1:0] target_en_i,
   input  logic [NumClusters-1:0] isolated_i,
   output logic [NumClusters-1:0] isolate_o,
   output logic [NumClusters-1:0] clk_en_o,
   output logic [NumClusters-1:0] clu_rst_no,
   output logic [NumClusters-1:0] active_o,
   output logic [NumClusters-1:0] busy_o,
   output logic [NumClusters-1:0] err_o,
   input  logic [NumClusters-1:0] err_clr_i
);

   for (genvar k = 0; k < NumClusters; k++) begin : gen_clu
      chimera_clu_pwr_fsm #(
         .RstHoldCycles (RstHoldCycles),
         .TimeoutCycles (TimeoutCycles)
      ) i_fsm (
         .clk_i       (soc_clk_i),
         .rst_ni      (rst_ni),
         .target_en_i (target_en_i[k]),
         .isolated_i  (isolated_i[k]),
         .err_clr_i   (err_clr_i[k]),
         .isolate_o   (isolate_o[k]),
         .clk_en_o    (clk_en_o[k]),
         .rst_no      (clu_rst_no[k]),
         .active_o    (active_o[k]),
         .busy_o      (busy_o[k]),
         .err_o       (err_o[k])
      );
   end

endmodule
